// File: rtl/instr_queue_mw_if.sv
`default_nettype none
// ============================================================================
// instr_queue_mw_if : fetch/decode handshake bundle for instr_queue_mw
// Rev 1.0
// ============================================================================
interface instr_queue_mw_if #(
  parameter int IF_WIDTH   = 2,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 64
) ();
  logic [IF_WIDTH-1:0]            enq_valid_i;
  logic [IF_WIDTH*DATA_WIDTH-1:0] enq_data_i;
  logic                           enq_ready_o;
  logic [ID_WIDTH-1:0]            deq_valid_o;
  logic [ID_WIDTH*DATA_WIDTH-1:0] deq_data_o;
  logic [ID_WIDTH-1:0]            deq_accept_i;

  modport master (
    output enq_valid_i, enq_data_i, deq_accept_i,
    input  enq_ready_o, deq_valid_o, deq_data_o
  );

  modport slave (
    input  enq_valid_i, enq_data_i, deq_accept_i,
    output enq_ready_o, deq_valid_o, deq_data_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_queue_mw.sv
`default_nettype none
// ============================================================================
// instr_queue_mw : multi-lane circular instruction queue, IF -> ID, with flush
// Rev 1.0
// ============================================================================
module instr_queue_mw #(
  parameter int IF_WIDTH   = 2,
  parameter int ID_WIDTH   = 2,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         flush_i,
  instr_queue_mw_if.slave                   q_if,
  output logic [$clog2(DEPTH+1)-1:0]        count_o,
  output logic                              empty_o,
  output logic                              full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  enq_ready;
  logic                  enq_fire;
  logic [CNT_W-1:0]      n_enq;
  logic [CNT_W-1:0]      n_deq;
  logic [ID_WIDTH-1:0]   deq_valid;

  // Credit is taken from registered occupancy only, so a same-cycle dequeue never frees room.
  assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IF_WIDTH);
  assign enq_fire  = enq_ready & ~flush_i;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  for (genvar j = 0; j < IF_WIDTH; j++) begin : g_enq
    logic [CNT_W-1:0] off;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] addr;
    if (j == 0) begin : g_first
      assign off = '0;
    end else begin : g_next
      assign off = g_enq[j-1].cnt;
    end
    assign cnt  = off + CNT_W'(q_if.enq_valid_i[j]);
    assign addr = wr_ptr_q + off[PTR_W-1:0];
  end
  assign n_enq = g_enq[IF_WIDTH-1].cnt;

  // Valid lanes have distinct offsets, so at most one lane targets any slot.
  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    for (genvar j = 0; j < IF_WIDTH; j++) begin : g_lane
      logic                  hit;
      logic                  hit_any;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  hit_prev;
      logic [DATA_WIDTH-1:0] wdata_prev;
      if (j == 0) begin : g_first
        assign hit_prev   = 1'b0;
        assign wdata_prev = '0;
      end else begin : g_next
        assign hit_prev   = g_slot[s].g_lane[j-1].hit_any;
        assign wdata_prev = g_slot[s].g_lane[j-1].wdata;
      end
      assign hit     = enq_fire & q_if.enq_valid_i[j] & (g_enq[j].addr == PTR_W'(s));
      assign hit_any = hit_prev | hit;
      assign wdata   = wdata_prev | (hit ? q_if.enq_data_i[j*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
    assign mem_d[s] = g_lane[IF_WIDTH-1].hit_any ? g_lane[IF_WIDTH-1].wdata : mem_q[s];
  end

  // Only an unbroken run of accepted valid lanes from lane 0 retires.
  for (genvar i = 0; i < ID_WIDTH; i++) begin : g_deq
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             run_prev;
    logic [CNT_W-1:0] cnt_prev;
    if (i == 0) begin : g_first
      assign run_prev = 1'b1;
      assign cnt_prev = '0;
    end else begin : g_next
      assign run_prev = g_deq[i-1].run;
      assign cnt_prev = g_deq[i-1].cnt;
    end
    assign deq_valid[i] = count_q > CNT_W'(i);
    assign run          = run_prev & q_if.deq_accept_i[i] & deq_valid[i];
    assign cnt          = cnt_prev + CNT_W'(run);
    assign q_if.deq_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
      deq_valid[i] ? mem_q[rd_ptr_q + PTR_W'(i)] : '0;
  end
  assign n_deq = g_deq[ID_WIDTH-1].cnt;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + n_deq[PTR_W-1:0];
      wr_ptr_d = wr_ptr_q + (enq_fire ? n_enq[PTR_W-1:0] : '0);
      count_d  = count_q + (enq_fire ? n_enq : '0) - n_deq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign q_if.enq_ready_o = enq_ready;
  assign q_if.deq_valid_o = deq_valid;
  assign count_o          = count_q;
  assign empty_o          = (count_q == '0);
  assign full_o           = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_instr_queue_mw.sv
`default_nettype none
// ============================================================================
// tb_instr_queue_mw : randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
module tb_instr_queue_mw;

  localparam int IFW   = 2;
  localparam int IDW   = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 64;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
  logic       empty;
  logic       full;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq[$];

  instr_queue_mw_if #(.IF_WIDTH(IFW), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) q_if ();

  instr_queue_mw #(
    .IF_WIDTH(IFW), .ID_WIDTH(IDW), .DEPTH(DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .q_if    (q_if),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    check_eq({tag, "_count"}, DW'(count), DW'(sz));
    check_eq({tag, "_empty"}, DW'(empty), DW'(sz == 0));
    check_eq({tag, "_full"},  DW'(full),  DW'(sz == DEPTH));
    check_eq({tag, "_ready"}, DW'(q_if.enq_ready_o), DW'((DEPTH - sz) >= IFW));
    check_eq({tag, "_dvalid"}, DW'(q_if.deq_valid_o), DW'({sz > 1, sz > 0}));
    check_eq({tag, "_d0"}, q_if.deq_data_o[DW-1:0],    (sz > 0) ? mq[0] : '0);
    check_eq({tag, "_d1"}, q_if.deq_data_o[2*DW-1:DW], (sz > 1) ? mq[1] : '0);
    check_eq({tag, "_bound"}, DW'(count <= 4'(DEPTH)), DW'(1));
  endtask

  task automatic step(input string tag, input logic fl, input logic [1:0] ev,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] acc);
    int  nd;
    bit  rdy;
    @(negedge clk);
    flush             = fl;
    q_if.enq_valid_i  = ev;
    q_if.enq_data_i   = {d1, d0};
    q_if.deq_accept_i = acc;
    #1;
    check_model(tag);
    if (fl) begin
      mq.delete();
    end else begin
      rdy = (DEPTH - mq.size()) >= IFW;
      nd  = 0;
      if (acc[0] && mq.size() > 0) begin
        nd = 1;
        if (acc[1] && mq.size() > 1) nd = 2;
      end
      repeat (nd) void'(mq.pop_front());
      if (rdy) begin
        if (ev[0]) mq.push_back(d0);
        if (ev[1]) mq.push_back(d1);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    flush             = 1'b0;
    q_if.enq_valid_i  = '0;
    q_if.enq_data_i   = '0;
    q_if.deq_accept_i = '0;
  endtask

  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check_eq({tag, "_count"},  DW'(count), DW'(0));
    check_eq({tag, "_empty"},  DW'(empty), DW'(1));
    check_eq({tag, "_full"},   DW'(full),  DW'(0));
    check_eq({tag, "_ready"},  DW'(q_if.enq_ready_o), DW'(1));
    check_eq({tag, "_dvalid"}, DW'(q_if.deq_valid_o), DW'(0));
    check_eq({tag, "_ddata"},  DW'(q_if.deq_data_o != '0), DW'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] a, b, x;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check_eq("rst_count", DW'(count), DW'(0));
    check_eq("rst_empty", DW'(empty), DW'(1));
    check_eq("rst_ready", DW'(q_if.enq_ready_o), DW'(1));
    check_eq("rst_dvalid", DW'(q_if.deq_valid_o), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Full bundle then visible next cycle.
    a = 64'hAAAA_0000_0000_000A;
    b = 64'hBBBB_0000_0000_000B;
    step("t1", 1'b0, 2'b11, a, b, 2'b00);
    check_eq("t1_count",  DW'(count), DW'(2));
    check_eq("t1_dvalid", DW'(q_if.deq_valid_o), DW'(2'b11));
    check_eq("t1_d0",     q_if.deq_data_o[DW-1:0], a);
    check_eq("t1_d1",     q_if.deq_data_o[2*DW-1:DW], b);
    check_eq("t1_ready",  DW'(q_if.enq_ready_o), DW'(1));

    // Sparse lane compacts to deq lane 0.
    step("t2f", 1'b1, 2'b00, '0, '0, 2'b00);
    x = 64'h0123_4567_89AB_CDEF;
    step("t2", 1'b0, 2'b10, 64'hDEAD, x, 2'b00);
    check_eq("t2_count",  DW'(count), DW'(1));
    check_eq("t2_dvalid", DW'(q_if.deq_valid_o), DW'(2'b01));
    check_eq("t2_d0",     q_if.deq_data_o[DW-1:0], x);

    // Fill to 7, bundle presented while not ready is ignored.
    step("t3a", 1'b0, 2'b11, 64'h11, 64'h12, 2'b00);
    step("t3b", 1'b0, 2'b11, 64'h13, 64'h14, 2'b00);
    step("t3c", 1'b0, 2'b11, 64'h15, 64'h16, 2'b00);
    check_eq("t3_count7", DW'(count), DW'(7));
    check_eq("t3_notready", DW'(q_if.enq_ready_o), DW'(0));
    step("t3d", 1'b0, 2'b11, 64'h77, 64'h78, 2'b00);
    check_eq("t3_hold7", DW'(count), DW'(7));
    step("t3e", 1'b0, 2'b00, '0, '0, 2'b01);
    check_eq("t3_count6", DW'(count), DW'(6));
    check_eq("t3_ready", DW'(q_if.enq_ready_o), DW'(1));
    check_eq("t3_head", q_if.deq_data_o[DW-1:0], 64'h11);

    // Non-prefix accept retires nothing.
    step("t5f", 1'b1, 2'b00, '0, '0, 2'b00);
    step("t5a", 1'b0, 2'b11, 64'h51, 64'h52, 2'b00);
    step("t5b", 1'b0, 2'b00, '0, '0, 2'b10);
    check_eq("t5_count", DW'(count), DW'(2));
    check_eq("t5_head",  q_if.deq_data_o[DW-1:0], 64'h51);

    // Flush with concurrent enqueue and dequeue.
    step("t6a", 1'b0, 2'b11, 64'h61, 64'h62, 2'b00);
    step("t6b", 1'b0, 2'b01, 64'h63, 64'h0, 2'b00);
    check_eq("t6_count5", DW'(count), DW'(5));
    step("t6c", 1'b1, 2'b11, 64'h64, 64'h65, 2'b11);
    check_eq("t6_count",  DW'(count), DW'(0));
    check_eq("t6_empty",  DW'(empty), DW'(1));
    check_eq("t6_dvalid", DW'(q_if.deq_valid_o), DW'(0));
    check_eq("t6_ready",  DW'(q_if.enq_ready_o), DW'(1));

    // Mixed 2-in/2-out wrap traffic.
    for (int c = 0; c < 40; c++) begin
      step("wrap", 1'b0, 2'b11, {32'hC0DE, 32'(2*c)}, {32'hC0DE, 32'(2*c+1)},
           (c < 3) ? 2'b00 : 2'b11);
    end

    // Randomized traffic with occasional flush and async reset.
    for (int c = 0; c < 600; c++) begin
      logic [1:0] ev, acc;
      logic       fl;
      ev  = 2'($urandom_range(0, 3));
      acc = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 29) == 0);
      if (c % 100 < 30) acc = acc & 2'($urandom_range(0, 1));
      step("rnd", fl, ev, {$urandom, $urandom}, {$urandom, $urandom}, acc);
      if (c == 300) async_reset("arst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
